// File: rtl/mc_ctrl_pkg.sv
// Shared constants, state encoding and control-bundle type for the multicycle MIPS controller.
// Optional MC_CTRL_PERF_EN build (see mc_control_fsm) adds performance counters.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_HALT   = 4'd12
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B        = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR     = 2'b01;
    localparam logic [1:0] ALUSRCB_SEXT     = 2'b10;
    localparam logic [1:0] ALUSRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdest;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-datapath-control decoder; only FETCH looks at mem_ready
// so the IR and PC load exactly on the cycle the instruction word arrives.
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
                ctrl_o.irwrite = mem_ready_i;
                ctrl_o.pcwrite = mem_ready_i;
                ctrl_o.pcsrc   = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctrl_o.alusrcb = ALUSRCB_SEXT_SH2;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_SEXT;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_o.memwrite = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_B;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl_o.regdest  = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alusrca     = 1'b1;
                ctrl_o.alusrcb     = ALUSRCB_B;
                ctrl_o.aluop       = ALUOP_SUB;
                ctrl_o.pcwritecond = 1'b1;
                ctrl_o.pcsrc       = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.pcsrc   = PCSRC_JUMP;
            end
            ST_ADDIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory-ready handshake, addi, illegal flag and sticky HALT.
// Define MC_CTRL_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC+4 -> PC when memory ready
//  DECODE | branch target -> ALUOut, dispatch on opcode
//  MEMADR | base + offset for lw/sw
//  MEMRD  | data read, wait for memory
//  MEMWB  | MDR -> rt
//  MEMWR  | data write, wait for memory
//  EXEC   | R-type ALU operation
//  ALUWB  | ALUOut -> rd
//  BRANCH | beq compare, conditional PC load
//  JUMP   | jump target -> PC
//  ADDIEX | A + signext
//  ADDIWB | ALUOut -> rt
//  HALT   | stopped until reset
import mc_ctrl_pkg::*;

module mc_control_fsm #(
    parameter int                   OPCODE_W    = 6,
    parameter int                   ALUOP_W     = 2,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = 6'h3F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pcwrite,
    output logic                pcwritecond,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                irwrite,
    output logic                memtoreg,
    output logic                regdest,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [1:0]          pcsrc,
    output logic                illegal,
    output logic                halted,
`ifdef MC_CTRL_PERF_EN
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instr_cnt,
`endif
    output logic [3:0]          state
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                op_unknown;
    ctrl_t               ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op_unknown = 1'b0;
        case (state_q)
            ST_FETCH: if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                op_d = opcode;
                // HALT is tested first so a HALT_OPCODE override always wins.
                if (opcode == HALT_OPCODE)                   state_d = ST_HALT;
                else if (opcode == OPCODE_W'(OP_RTYPE))      state_d = ST_EXEC;
                else if (opcode == OPCODE_W'(OP_LW) ||
                         opcode == OPCODE_W'(OP_SW))         state_d = ST_MEMADR;
                else if (opcode == OPCODE_W'(OP_BEQ))        state_d = ST_BRANCH;
                else if (opcode == OPCODE_W'(OP_J))          state_d = ST_JUMP;
                else if (opcode == OPCODE_W'(OP_ADDI))       state_d = ST_ADDIEX;
                else begin
                    state_d    = ST_FETCH;
                    op_unknown = 1'b1;
                end
            end
            ST_MEMADR: state_d = (op_q == OPCODE_W'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_HALT:   state_d = ST_HALT;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        pcwrite     = ctrl.pcwrite;
        pcwritecond = ctrl.pcwritecond;
        iord        = ctrl.iord;
        memread     = ctrl.memread;
        memwrite    = ctrl.memwrite;
        irwrite     = ctrl.irwrite;
        memtoreg    = ctrl.memtoreg;
        regdest     = ctrl.regdest;
        regwrite    = ctrl.regwrite;
        alusrca     = ctrl.alusrca;
        alusrcb     = ctrl.alusrcb;
        aluop       = ALUOP_W'(ctrl.aluop);
        pcsrc       = ctrl.pcsrc;
        illegal     = op_unknown;
        halted      = (state_q == ST_HALT);
        state       = state_q;
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;
    logic        instr_done;

    // Illegal opcodes return to FETCH from DECODE, which is not a completing state.
    assign instr_done = (state_d == ST_FETCH) &&
                        (state_q inside {ST_MEMWB, ST_MEMWR, ST_ALUWB,
                                         ST_BRANCH, ST_JUMP, ST_ADDIWB});

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_done)         instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle stimulus and expected state/controls are queued, then replayed and checked.
// Counter checks are active when MC_CTRL_PERF_EN is defined.
module tb_mc_control_fsm;

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4,
                           S_MW = 4'd5, S_EX = 4'd6, S_AWB = 4'd7, S_BR = 4'd8, S_J = 4'd9,
                           S_AIE = 4'd10, S_AIW = 4'd11, S_H = 4'd12;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [5:0] op;
        logic [3:0] st;
        logic       ill;
    } entry_t;

    logic clk = 1'b0;
    logic reset, mem_ready;
    logic [5:0] opcode;
    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdest, regwrite;
    logic alusrca, illegal, halted;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    entry_t sb[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdest(regdest),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsrc(pcsrc), .illegal(illegal), .halted(halted),
`ifdef MC_CTRL_PERF_EN
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
        .state(state)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
        end
    endtask

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdest,regwrite,alusrca,alusrcb,aluop,pcsrc,illegal,halted}
    function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic ill);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, il, h;
        logic [1:0] sb_, op, ps;
        {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, il, h} = '0;
        sb_ = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            S_F:   begin mrd = 1; sb_ = 2'b01; irw = mr; pw = mr; end
            S_D:   begin sb_ = 2'b11; il = ill; end
            S_MA:  begin sa = 1; sb_ = 2'b10; end
            S_MR:  begin mrd = 1; io = 1; end
            S_MWB: begin rw = 1; m2r = 1; end
            S_MW:  begin mwr = 1; io = 1; end
            S_EX:  begin sa = 1; op = 2'b10; end
            S_AWB: begin rd = 1; rw = 1; end
            S_BR:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            S_J:   begin pw = 1; ps = 2'b10; end
            S_AIE: begin sa = 1; sb_ = 2'b10; end
            S_AIW: begin rw = 1; end
            S_H:   begin h = 1; end
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb_, op, ps, il, h};
    endfunction

    task automatic push(input logic rst, input logic mr, input logic [5:0] op,
                        input logic [3:0] st, input logic ill);
        entry_t e;
        e.rst = rst; e.mr = mr; e.op = op; e.st = st; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic push_fetch_decode(input logic [5:0] op, input int fetch_stalls, input logic ill);
        for (int i = 0; i < fetch_stalls; i++) push(0, 0, 6'h00, S_F, 0);
        push(0, 1, 6'h00, S_F, 0);
        push(0, 1, op, S_D, ill);
    endtask

    task automatic drain();
        entry_t e;
        logic [17:0] act;
        int cyc_exp = 0;
        int ins_exp = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            reset     = e.rst;
            mem_ready = e.mr;
            opcode    = (e.st == S_D) ? e.op : 6'($urandom);
            #1;
            act = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdest,
                   regwrite, alusrca, alusrcb, aluop, pcsrc, illegal, halted};
            check_eq("state", 32'(state), 32'(e.st));
            check_eq("ctrl", 32'(act), 32'(exp_ctrl(e.st, e.mr, e.ill)));
            check_eq("rd_wr_excl", 32'(memread & memwrite), 32'd0);
`ifdef MC_CTRL_PERF_EN
            check_eq("cycle_cnt", cycle_cnt, 32'(cyc_exp));
            check_eq("instr_cnt", instr_cnt, 32'(ins_exp));
`endif
            if (e.rst) begin
                cyc_exp = 0;
                ins_exp = 0;
            end else begin
                if (e.st != S_H) cyc_exp++;
                if (e.st inside {S_MWB, S_AWB, S_BR, S_J, S_AIW} || (e.st == S_MW && e.mr))
                    ins_exp++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
        repeat (2) @(posedge clk);
        push(1, 1, 6'h00, S_F, 0);

        // R-type
        push_fetch_decode(6'b000000, 0, 0);
        push(0, 1, 6'h00, S_EX, 0);
        push(0, 1, 6'h00, S_AWB, 0);
        // lw with two memory stalls
        push_fetch_decode(6'b100011, 0, 0);
        push(0, 1, 6'h00, S_MA, 0);
        push(0, 0, 6'h00, S_MR, 0);
        push(0, 0, 6'h00, S_MR, 0);
        push(0, 1, 6'h00, S_MR, 0);
        push(0, 1, 6'h00, S_MWB, 0);
        // sw, beq, j
        push_fetch_decode(6'b101011, 0, 0);
        push(0, 1, 6'h00, S_MA, 0);
        push(0, 1, 6'h00, S_MW, 0);
        push_fetch_decode(6'b000100, 0, 0);
        push(0, 1, 6'h00, S_BR, 0);
        push_fetch_decode(6'b000010, 0, 0);
        push(0, 1, 6'h00, S_J, 0);
        // addi behind a fetch stall
        push_fetch_decode(6'b001000, 1, 0);
        push(0, 1, 6'h00, S_AIE, 0);
        push(0, 1, 6'h00, S_AIW, 0);
        // illegal opcode
        push_fetch_decode(6'b010101, 0, 1);
        // sw with one write stall
        push_fetch_decode(6'b101011, 0, 0);
        push(0, 1, 6'h00, S_MA, 0);
        push(0, 0, 6'h00, S_MW, 0);
        push(0, 1, 6'h00, S_MW, 0);
        // halt, sticky for 20 cycles, then reset
        push_fetch_decode(6'h3F, 0, 0);
        for (int i = 0; i < 20; i++) push(0, 1, 6'h00, S_H, 0);
        push(1, 1, 6'h00, S_H, 0);
        push(0, 0, 6'h00, S_F, 0);
        // reset while MEMWR is stalled
        push_fetch_decode(6'b101011, 0, 0);
        push(0, 1, 6'h00, S_MA, 0);
        push(0, 0, 6'h00, S_MW, 0);
        push(1, 0, 6'h00, S_MW, 0);
        push(0, 0, 6'h00, S_F, 0);
        push(0, 1, 6'h00, S_F, 0);
        push(0, 1, 6'b000010, S_D, 0);
        push(0, 1, 6'h00, S_J, 0);
        push(0, 1, 6'h00, S_F, 0);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle successor to the single-cycle MIPS control unit: a Moore/Mealy FSM that sequences FETCH, DECODE, EXEC, MEM and WB per instruction.
- Drives datapath control signals for a shared-memory multicycle datapath, per P&H multicycle control.
- Adds a memory-ready handshake, addi support, illegal-opcode flagging and a sticky halt state.
- Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, aluop width toward the ALU control block.
- HALT_OPCODE, 6'h3F, opcode that enters HALT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- opcode  in  OPCODE_W  IR[31:26]; sampled only in DECODE
- mem_ready  in  1  memory completes the access this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if ALU zero
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load
- memtoreg  out  1  write-back source is MDR
- regdest  out  1  write-back register is rd
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = 4, 10 = signext, 11 = signext<<2
- aluop  out  ALUOP_W  00 = add, 01 = sub, 10 = funct
- pcsrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal  out  1  one-cycle pulse on unknown opcode
- halted  out  1  high while in HALT
- state  out  4  current state encoding, for debug

Behaviour:
- One clock. Reset is synchronous and active-high: on a clk edge with reset=1, state becomes FETCH and all registered flags clear.
- Outputs are combinational from state, plus mem_ready where noted. During and after reset every output is 0 except the FETCH decodes.
- Reset mid-instruction abandons the instruction. No write-back occurs.
- Default for every output is 0 in each state.
- State encodings:
  - 0 FETCH
  - 1 DECODE
  - 2 MEMADR
  - 3 MEMRD
  - 4 MEMWB
  - 5 MEMWR
  - 6 EXEC
  - 7 ALUWB
  - 8 BRANCH
  - 9 JUMP
  - 10 ADDIEX
  - 11 ADDIWB
  - 12 HALT
- FETCH:
  - Asserts memread, alusrcb=01, aluop=00.
  - irwrite and pcwrite are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE:
  - Asserts alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - HALT_OPCODE -> HALT
    - any other opcode -> FETCH, with illegal pulsed for that cycle
- MEMADR: asserts alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw; the opcode is held in a register captured in DECODE.
- MEMRD: asserts memread, iord. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: asserts regwrite, memtoreg. Goes to FETCH.
- MEMWR: asserts memwrite, iord. Holds until mem_ready=1, then goes to FETCH.
- EXEC: asserts alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
- ALUWB: asserts regdest, regwrite. Goes to FETCH.
- BRANCH: asserts alusrca=1, alusrcb=00, aluop=01, pcwritecond, pcsrc=01. Goes to FETCH.
- JUMP: asserts pcwrite, pcsrc=10. Goes to FETCH.
- ADDIEX: asserts alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: asserts regwrite (regdest=0, memtoreg=0). Goes to FETCH.
- HALT: halted=1, all other outputs 0. Sticky; only reset exits.
- Cycle counts with mem_ready tied to 1:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - addi 4
  - illegal 2
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- memread and memwrite are never asserted in the same cycle.
- opcode changing outside DECODE has no effect.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- When defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every non-reset cycle while not halted.
  - instr_cnt increments on each transition into FETCH from a completing state (MEMWB, MEMWR done, ALUWB, BRANCH, JUMP, ADDIWB), but not on the illegal-opcode return.
  - Both counters clear on reset and wrap modulo 2^32.
- When undefined: neither port nor counter logic exists.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT
  - the state enum with the fixed 4-bit encodings above
  - aluop, alusrcb and pcsrc encoding constants
- Natural sub-module: mc_ctrl_decode, a combinational state-to-output decoder.
- The FSM register and next-state logic stay in mc_control_fsm.

Test Plan:
- Reset held for 2 cycles, then released with mem_ready=1 and opcode=000000 -> state sequence 0, 1, 6, 7, 0. regwrite=1 and regdest=1 only in ALUWB.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> 7 cycles FETCH to FETCH. MEMWB asserts memtoreg=1 and regwrite=1.
- sw (101011), then beq (000100), then j (000010), mem_ready=1 -> 4, 3 and 3 cycles. memwrite only in MEMWR. pcwritecond=1 with pcsrc=01 in BRANCH. pcwrite=1 with pcsrc=10 in JUMP.
- opcode 010101 in DECODE -> illegal=1 for exactly one cycle, next state FETCH, no regwrite/memwrite. With MC_CTRL_PERF_EN, instr_cnt is unchanged.
- opcode 6'h3F -> halted=1 for 20 cycles, all other outputs 0. Reset asserted returns state to 0 on the next edge.
- Reset asserted during MEMWR with mem_ready=0 -> next cycle state=0, memwrite=0. With MC_CTRL_PERF_EN, cycle_cnt=0 and instr_cnt=0.
